mac_slot_ctrl: RTL and testbench

MAC_SLOT_CTRL -- requirements
Module: mac_slot_ctrl

---
 rtl/mac_slot_ctrl.sv | 153 +++++++++++++++
 tb/tb_mac_slot_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_slot_ctrl.sv
// rtl/mac_slot_ctrl.sv - slotted-ALOHA reply arbiter for a backscatter tag.
// MAC_SLOT_CTRL_RSS_GATE_EN adds the WAIT_RSS state that gates replies on probe RSS.
module mac_slot_ctrl #(
  parameter int unsigned Q_DEFAULT  = 2,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter logic [7:0]  RSS_THRESH = 8'h80
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic [3:0]  q_in,
  input  logic        slot_tick,
  input  logic        rss_valid,
  input  logic [7:0]  rss,
  input  logic        mod_done,
  input  logic        ack,
  input  logic        nak,
  output logic        mod_grant,
  output logic [15:0] slot_cnt,
  output logic        tag_done,
  output logic [7:0]  coll_cnt
);

  localparam logic [3:0] Q_RST = (Q_DEFAULT > 15) ? 4'd15 : 4'(Q_DEFAULT);

`ifdef MAC_SLOT_CTRL_RSS_GATE_EN
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_SLOT = 3'd1,
    WAIT_RSS  = 3'd2,
    REPLY     = 3'd3,
    WAIT_ACK  = 3'd4,
    DONE      = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_SLOT = 3'd1,
    REPLY     = 3'd3,
    WAIT_ACK  = 3'd4,
    DONE      = 3'd5
  } state_t;

  logic unused_rss;
  assign unused_rss = ^{rss, rss_valid};
`endif

  state_t      state_q, state_d;
  logic [3:0]  q_q, q_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [15:0] slot_q, slot_d;
  logic [7:0]  coll_q, coll_d;
  logic        done_q, done_d;
  logic        grant_q, grant_d;
  logic        redraw;

  function automatic logic [15:0] slot_mask(input logic [3:0] q);
    return (16'd1 << q) - 16'd1;
  endfunction

  // Right-shifting Galois form; taps 0xB400 realise x^16+x^14+x^13+x^11+1.
  assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    slot_d  = slot_q;
    coll_d  = coll_q;
    done_d  = done_q;
    redraw  = 1'b0;

    if (frame_start) begin
      q_d     = q_in;
      slot_d  = lfsr_q & slot_mask(q_in);
      coll_d  = 8'd0;
      done_d  = 1'b0;
      state_d = WAIT_SLOT;
    end else begin
      case (state_q)
        WAIT_SLOT: begin
          if (slot_tick) begin
            if (slot_q == 16'd0) begin
`ifdef MAC_SLOT_CTRL_RSS_GATE_EN
              state_d = WAIT_RSS;
`else
              state_d = REPLY;
`endif
            end else begin
              slot_d = slot_q - 16'd1;
            end
          end
        end
`ifdef MAC_SLOT_CTRL_RSS_GATE_EN
        WAIT_RSS: begin
          if (rss_valid) begin
            if (rss >= RSS_THRESH) state_d = REPLY;
            else                   redraw  = 1'b1;
          end else if (slot_tick) begin
            redraw = 1'b1;
          end
        end
`endif
        REPLY: begin
          if (mod_done) state_d = WAIT_ACK;
        end
        WAIT_ACK: begin
          if (ack) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else if (nak || slot_tick) begin
            if (coll_q != 8'hFF) coll_d = coll_q + 8'd1;
            redraw = 1'b1;
          end
        end
        default: ;
      endcase

      if (redraw) begin
        slot_d  = lfsr_q & slot_mask(q_q);
        state_d = WAIT_SLOT;
      end
    end

    grant_d = (state_d == REPLY);
  end

  // Grant is a flop with async clear so reset silences the modulator at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      q_q     <= Q_RST;
      lfsr_q  <= LFSR_SEED;
      slot_q  <= 16'd0;
      coll_q  <= 8'd0;
      done_q  <= 1'b0;
      grant_q <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      lfsr_q  <= lfsr_d;
      slot_q  <= slot_d;
      coll_q  <= coll_d;
      done_q  <= done_d;
      grant_q <= grant_d;
    end
  end

  assign mod_grant = grant_q;
  assign slot_cnt  = slot_q;
  assign tag_done  = done_q;
  assign coll_cnt  = coll_q;

endmodule

// File: tb/tb_mac_slot_ctrl.sv
// tb/tb_mac_slot_ctrl.sv - directed vector bench for mac_slot_ctrl.
module tb_mac_slot_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        frame_start = 1'b0;
  logic [3:0]  q_in = 4'd0;
  logic        slot_tick = 1'b0;
  logic        rss_valid = 1'b0;
  logic [7:0]  rss = 8'd0;
  logic        mod_done = 1'b0;
  logic        ack = 1'b0;
  logic        nak = 1'b0;
  logic        mod_grant;
  logic [15:0] slot_cnt;
  logic        tag_done;
  logic [7:0]  coll_cnt;

  int n_vec = 0;
  int n_bad = 0;

  mac_slot_ctrl dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .q_in(q_in),
    .slot_tick(slot_tick), .rss_valid(rss_valid), .rss(rss),
    .mod_done(mod_done), .ack(ack), .nak(nak), .mod_grant(mod_grant),
    .slot_cnt(slot_cnt), .tag_done(tag_done), .coll_cnt(coll_cnt)
  );

  always #10 clk = ~clk;

  // Independent reference LFSR for x^16+x^14+x^13+x^11+1 from seed 0xACE1.
  logic [15:0] m_lfsr;
  always @(posedge clk or negedge reset) begin
    if (!reset) m_lfsr <= 16'hACE1;
    else        m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
  end

  typedef struct {
    logic       fs;
    logic [3:0] q;
    logic       tk, rv;
    logic [7:0] rs;
    logic       md, ak, nk;
    logic       e_grant, e_done;
    logic [7:0] e_coll;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic fs, input logic [3:0] q, input logic tk, input logic rv,
                     input logic [7:0] rs, input logic md, input logic ak, input logic nk,
                     input logic eg, input logic ed, input logic [7:0] ec);
    vec_t v;
    v.fs = fs; v.q = q; v.tk = tk; v.rv = rv; v.rs = rs;
    v.md = md; v.ak = ak; v.nk = nk;
    v.e_grant = eg; v.e_done = ed; v.e_coll = ec;
    vecs.push_back(v);
  endtask

  task automatic add_reply(input logic [7:0] ec);
`ifdef MAC_SLOT_CTRL_RSS_GATE_EN
    add(0, 0, 1, 0, 8'h00, 0, 0, 0, 0, 0, ec);
    add(0, 0, 0, 1, 8'hA0, 0, 0, 0, 1, 0, ec);
`else
    add(0, 0, 1, 0, 8'h00, 0, 0, 0, 1, 0, ec);
`endif
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fs, input logic [3:0] q, input logic tk, input logic rv,
                       input logic [7:0] rs, input logic md, input logic ak, input logic nk);
    frame_start = fs; q_in = q; slot_tick = tk; rss_valid = rv; rss = rs;
    mod_done = md; ack = ak; nak = nk;
    @(posedge clk);
    @(negedge clk);
    frame_start = 0; slot_tick = 0; rss_valid = 0; mod_done = 0; ack = 0; nak = 0;
  endtask

  // From WAIT_SLOT with slot_cnt==0 into REPLY.
  task automatic reach_reply();
    drive(0, 0, 1, 0, 8'h00, 0, 0, 0);
`ifdef MAC_SLOT_CTRL_RSS_GATE_EN
    drive(0, 0, 0, 1, 8'hA0, 0, 0, 0);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp_slot;
    int spins;

    repeat (3) @(negedge clk);
    chk("rst.grant", mod_grant, 0);
    chk("rst.slot", slot_cnt, 0);
    chk("rst.done", tag_done, 0);
    chk("rst.coll", coll_cnt, 0);
    reset = 1'b1;

    add(0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 8'h00, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 8'hFF, 1, 1, 1, 0, 0, 0);
    add(1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0);
`ifdef MAC_SLOT_CTRL_RSS_GATE_EN
    add(0, 0, 0, 1, 8'hA0, 0, 0, 0, 0, 0, 0);
`endif
    add_reply(0);
    add(0, 0, 0, 0, 8'h00, 0, 1, 0, 1, 0, 0);
    add(0, 0, 0, 0, 8'h00, 0, 0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 8'h00, 0, 1, 0, 0, 1, 0);
    add(0, 0, 1, 0, 8'h00, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 8'h00, 0, 0, 1, 0, 1, 0);
    add(1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0);
    add_reply(0);
    add(0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 8'h00, 0, 0, 1, 0, 0, 1);
    add_reply(1);
    add(0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 1);
    add(0, 0, 1, 0, 8'h00, 0, 0, 0, 0, 0, 2);
    add_reply(2);
    add(0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 2);
    add(0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 2);
    add(0, 0, 0, 0, 8'h00, 0, 1, 1, 0, 1, 2);
    add(1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].fs, vecs[i].q, vecs[i].tk, vecs[i].rv, vecs[i].rs,
            vecs[i].md, vecs[i].ak, vecs[i].nk);
      chk($sformatf("vec%0d.grant", i), mod_grant, vecs[i].e_grant);
      chk($sformatf("vec%0d.done", i), tag_done, vecs[i].e_done);
      chk($sformatf("vec%0d.coll", i), coll_cnt, vecs[i].e_coll);
      chk($sformatf("vec%0d.slot", i), slot_cnt, 0);
    end

    // Countdown from a known draw of 3 with Q=4.
    spins = 0;
    while (m_lfsr[3:0] != 4'd3 && spins < 2000) begin
      @(negedge clk);
      spins++;
    end
    chk("q4.lfsr_search", (m_lfsr[3:0] == 4'd3), 1);
    drive(1, 4, 0, 0, 8'h00, 0, 0, 0);
    chk("q4.load", slot_cnt, 3);
    for (int k = 2; k >= 0; k--) begin
      drive(0, 0, 1, 0, 8'h00, 0, 0, 0);
      chk($sformatf("q4.tick_to_%0d", k), slot_cnt, k);
      chk($sformatf("q4.grant_%0d", k), mod_grant, 0);
    end
    drive(0, 0, 1, 0, 8'h00, 0, 0, 0);
`ifdef MAC_SLOT_CTRL_RSS_GATE_EN
    chk("q4.wait_rss_grant", mod_grant, 0);
    exp_slot = m_lfsr & 16'h000F;
    drive(0, 0, 0, 1, 8'h7F, 0, 0, 0);
    chk("lowrss.grant", mod_grant, 0);
    chk("lowrss.redraw", slot_cnt, exp_slot);
    chk("lowrss.range", (slot_cnt <= 16'd15), 1);
`else
    chk("q4.slot0_grant", mod_grant, 1);
    drive(0, 0, 0, 0, 8'h00, 1, 0, 0);
    chk("q4.md_grant", mod_grant, 0);
    exp_slot = m_lfsr & 16'h000F;
    drive(0, 0, 0, 0, 8'h00, 0, 0, 1);
    chk("nak.redraw", slot_cnt, exp_slot);
    chk("nak.range", (slot_cnt <= 16'd15), 1);
    chk("nak.coll", coll_cnt, 1);
`endif

    // frame_start and slot_tick together in REPLY.
    drive(1, 0, 0, 0, 8'h00, 0, 0, 0);
    reach_reply();
    chk("fsprio.pre_grant", mod_grant, 1);
    exp_slot = m_lfsr & 16'h000F;
    drive(1, 4, 1, 0, 8'h00, 0, 0, 0);
    chk("fsprio.grant", mod_grant, 0);
    chk("fsprio.slot", slot_cnt, exp_slot);
    drive(0, 0, 0, 0, 8'h00, 0, 0, 0);
    chk("fsprio.hold", slot_cnt, exp_slot);
    drive(0, 0, 1, 0, 8'h00, 0, 0, 0);
    if (exp_slot != 16'd0) begin
      chk("fsprio.dec", slot_cnt, exp_slot - 16'd1);
    end else begin
`ifdef MAC_SLOT_CTRL_RSS_GATE_EN
      chk("fsprio.slot0", mod_grant, 0);
`else
      chk("fsprio.slot0", mod_grant, 1);
`endif
    end

    // Collision counter saturation.
    drive(1, 0, 0, 0, 8'h00, 0, 0, 0);
    for (int n = 1; n <= 300; n++) begin
      reach_reply();
      drive(0, 0, 0, 0, 8'h00, 1, 0, 0);
      drive(0, 0, 0, 0, 8'h00, 0, 0, 1);
      if (n == 200) chk("sat.n200", coll_cnt, 200);
      if (n == 255) chk("sat.n255", coll_cnt, 255);
    end
    chk("sat.n300", coll_cnt, 255);

    // Asynchronous reset mid-REPLY.
    drive(1, 0, 0, 0, 8'h00, 0, 0, 0);
    reach_reply();
    chk("arst.pre_grant", mod_grant, 1);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("arst.grant", mod_grant, 0);
    chk("arst.coll", coll_cnt, 0);
    chk("arst.slot", slot_cnt, 0);
    @(negedge clk);
    reset = 1'b1;
    drive(0, 0, 1, 0, 8'hFF, 1, 1, 1);
    chk("idle.ignore_grant", mod_grant, 0);
    chk("idle.ignore_coll", coll_cnt, 0);
    drive(1, 0, 0, 0, 8'h00, 0, 0, 0);
    drive(0, 0, 1, 0, 8'h00, 0, 0, 0);
`ifdef MAC_SLOT_CTRL_RSS_GATE_EN
    chk("nogate.slot0", mod_grant, 0);
`else
    chk("nogate.slot0", mod_grant, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
